// File: rtl/random_block_field_if.sv
// Pixel/control bus for random_block_field: raster position and screen size in,
// registered colour, slot occupancy and drop counter out.
interface random_block_field_if #(
    parameter int N_BLOCKS = 4
) ();
    logic                move_tick;
    logic                disp_active;
    logic [10:0]         xpos;
    logic [10:0]         ypos;
    logic [10:0]         h_resolution;
    logic [10:0]         v_resolution;
    logic [3:0]          R;
    logic [3:0]          G;
    logic [3:0]          B;
    logic [N_BLOCKS-1:0] active;
    logic [7:0]          drop_count;

    modport master (
        output move_tick, disp_active, xpos, ypos, h_resolution, v_resolution,
        input  R, G, B, active, drop_count
    );

    modport slave (
        input  move_tick, disp_active, xpos, ypos, h_resolution, v_resolution,
        output R, G, B, active, drop_count
    );
endinterface

// File: rtl/random_block_field.sv
// Blocks spawned at LFSR-chosen rows on the right edge scroll left on move_tick and are
// drawn into a registered RGB stream. Define RANDOM_BLOCK_COLOR_EN for per-block random colours.
module random_block_field #(
    parameter int          N_BLOCKS    = 4,
    parameter int          BLOCK_SIZE  = 10,
    parameter int          STEP        = 3,
    parameter int          SPAWN_TICKS = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic                 clock,
    input logic                 reset_n,
    random_block_field_if.slave bus
);

    localparam int               CNT_W    = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam int               IDX_W    = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_TICKS - 1);
    localparam logic [10:0]      SIZE_11  = 11'(BLOCK_SIZE);
    localparam logic [11:0]      SIZE_12  = 12'(BLOCK_SIZE);
    localparam logic [10:0]      STEP_11  = 11'(STEP);
    localparam logic [10:0]      MOVE_MIN = 11'(BLOCK_SIZE + STEP);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } slot_state_e;

    slot_state_e         state_q [N_BLOCKS];
    slot_state_e         state_d [N_BLOCKS];
    logic [10:0]         x_q     [N_BLOCKS];
    logic [10:0]         x_d     [N_BLOCKS];
    logic [10:0]         y_q     [N_BLOCKS];
    logic [10:0]         y_d     [N_BLOCKS];
`ifdef RANDOM_BLOCK_COLOR_EN
    logic [11:0]         col_q   [N_BLOCKS];
    logic [11:0]         col_d   [N_BLOCKS];
    logic [11:0]         spawn_col;
`endif
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [7:0]          drop_q, drop_d;
    logic [3:0]          r_q, g_q, b_q;
    logic [3:0]          r_d, g_d, b_d;
    logic [10:0]         cand;
    logic                cand_ok;
    logic                spawn_req;
    logic                spawn_try;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic                hit;
    logic [11:0]         hit_col;
    logic [N_BLOCKS-1:0] act_vec;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Spawn scheduling: tick counter, candidate qualification, retry flag, free-slot search
    always_comb begin
        lfsr_d    = lfsr_step(lfsr_q);
        cand      = lfsr_q[10:0];
        cand_ok   = (cand >= SIZE_11) && (cand < bus.v_resolution);
        spawn_req = bus.move_tick && (cnt_q == CNT_LAST);
        spawn_try = spawn_req || (pend_q && bus.move_tick);

        cnt_d = cnt_q;
        if (bus.move_tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end

        pend_d = spawn_try ? !cand_ok : pend_q;

        free_found = 1'b0;
        free_idx   = '0;
        for (int k = 0; k < N_BLOCKS; k++) begin
            if (!free_found && state_q[k] == S_IDLE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
        end

        drop_d = (spawn_try && cand_ok && !free_found) ? sat_inc8(drop_q) : drop_q;

`ifdef RANDOM_BLOCK_COLOR_EN
        spawn_col = {lfsr_q[15:12], lfsr_q[11:8], lfsr_q[3:0]};
        if (spawn_col == 12'h000) begin
            spawn_col = 12'hF00;
        end
`endif
    end

    // Slot FSM next state: an IDLE slot can only spawn, so it never moves in its spawn cycle,
    // and a slot leaving this cycle is still ACTIVE in state_q, so it is not picked as free.
    always_comb begin
        for (int k = 0; k < N_BLOCKS; k++) begin
            state_d[k] = state_q[k];
            x_d[k]     = x_q[k];
            y_d[k]     = y_q[k];
`ifdef RANDOM_BLOCK_COLOR_EN
            col_d[k]   = col_q[k];
`endif
            if (state_q[k] == S_ACTIVE) begin
                if (bus.move_tick) begin
                    if (x_q[k] >= MOVE_MIN) begin
                        x_d[k] = x_q[k] - STEP_11;
                    end else begin
                        state_d[k] = S_IDLE;
                    end
                end
            end else if (spawn_try && cand_ok && free_found && (free_idx == IDX_W'(k))) begin
                state_d[k] = S_ACTIVE;
                x_d[k]     = bus.h_resolution - 11'd1;
                y_d[k]     = cand;
`ifdef RANDOM_BLOCK_COLOR_EN
                col_d[k]   = spawn_col;
`endif
            end
        end
    end

    // Pixel hit: compare with BLOCK_SIZE added on the pixel side so nothing underflows
    always_comb begin
        hit     = 1'b0;
        hit_col = 12'hF00;
        for (int k = 0; k < N_BLOCKS; k++) begin
            if (!hit && state_q[k] == S_ACTIVE
                && (({1'b0, bus.xpos} + SIZE_12) > {1'b0, x_q[k]}) && (bus.xpos < x_q[k])
                && (({1'b0, bus.ypos} + SIZE_12) > {1'b0, y_q[k]}) && (bus.ypos < y_q[k])) begin
                hit = 1'b1;
`ifdef RANDOM_BLOCK_COLOR_EN
                hit_col = col_q[k];
`endif
            end
        end
        r_d = 4'h0;
        g_d = 4'h0;
        b_d = 4'h0;
        if (hit && bus.disp_active) begin
            {r_d, g_d, b_d} = hit_col;
        end
    end

    always_comb begin
        for (int k = 0; k < N_BLOCKS; k++) begin
            act_vec[k] = (state_q[k] == S_ACTIVE);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_BLOCKS; k++) begin
                state_q[k] <= S_IDLE;
                x_q[k]     <= '0;
                y_q[k]     <= '0;
`ifdef RANDOM_BLOCK_COLOR_EN
                col_q[k]   <= '0;
`endif
            end
            lfsr_q <= LFSR_SEED;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            drop_q <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            for (int k = 0; k < N_BLOCKS; k++) begin
                state_q[k] <= state_d[k];
                x_q[k]     <= x_d[k];
                y_q[k]     <= y_d[k];
`ifdef RANDOM_BLOCK_COLOR_EN
                col_q[k]   <= col_d[k];
`endif
            end
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            drop_q <= drop_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    assign bus.R          = r_q;
    assign bus.G          = g_q;
    assign bus.B          = b_q;
    assign bus.active     = act_vec;
    assign bus.drop_count = drop_q;

endmodule

// File: doc/random_block_field.md
RANDOM_BLOCK_FIELD -- requirements
Module: random_block_field

Interface
REQ-001 SHALL have parameter N_BLOCKS, default 4, meaning number of independent block slots (1..8).
REQ-002 SHALL have parameter BLOCK_SIZE, default 10, meaning block edge in pixels.
REQ-003 SHALL have parameter STEP, default 3, meaning pixels moved left per move_tick.
REQ-004 SHALL have parameter SPAWN_TICKS, default 16, meaning move_ticks between spawn attempts.
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning LFSR reset value (nonzero).
REQ-006 SHALL have ports: clock  in  1  single system clock, all logic on rising edge.
REQ-007 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: move_tick  in  1  one-clock movement strobe.
REQ-009 SHALL have ports: disp_active  in  1  visible-area flag.
REQ-010 SHALL have ports: xpos, ypos  in  11 each  current pixel coordinate.
REQ-011 SHALL have ports: h_resolution, v_resolution  in  11 each  screen size, static during operation.
REQ-012 SHALL have ports: R, G, B  out  4 each  registered pixel colour.
REQ-013 SHALL have ports: active  out  N_BLOCKS  slot-occupied vector.
REQ-014 SHALL have ports: drop_count  out  8  saturating count of spawns lost to full field.

Function
REQ-015 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every clock.
REQ-016 SHALL keep per slot: state IDLE/ACTIVE, x[10:0], y[10:0].
REQ-017 SHALL count move_ticks modulo SPAWN_TICKS; wrap to 0 raises a spawn request for that cycle.
REQ-018 On spawn request, SHALL form candidate = lfsr[10:0]; valid if BLOCK_SIZE <= candidate <= v_resolution-1.
REQ-019 Valid candidate and free slot: lowest-index IDLE slot SHALL go ACTIVE with x = h_resolution-1, y = candidate.
REQ-020 Invalid candidate: spawn SHALL retry on each following move_tick until valid; counter keeps running; a new request while retrying merges into the pending one.
REQ-021 Valid candidate and all slots ACTIVE: spawn SHALL be discarded, drop_count incremented, saturating at 255.
REQ-022 On move_tick, every ACTIVE slot with x >= BLOCK_SIZE+STEP SHALL take x <= x-STEP; otherwise it SHALL return to IDLE (leaves left edge).
REQ-023 A slot spawned in a cycle SHALL NOT move in that same cycle; a slot freed in a cycle SHALL NOT be reused until the next cycle.
REQ-024 Pixel hit for slot k SHALL be: ACTIVE and x-BLOCK_SIZE < xpos < x and y-BLOCK_SIZE < ypos < y (strict, unsigned, 12-bit compare so no underflow wrap).
REQ-025 Overlapping hits SHALL resolve to the lowest-index slot.
REQ-026 R/G/B SHALL be registered with 1-clock latency from xpos/ypos/disp_active; 0 when disp_active=0 or no hit.
REQ-027 active[k] SHALL equal slot k state ACTIVE, updated same edge as state.

Reset
REQ-028 reset_n low SHALL immediately clear all slots to IDLE, x=y=0, R=G=B=0, active=0, drop_count=0, spawn counter=0, pending retry=0, LFSR=LFSR_SEED.
REQ-029 Reset asserted mid-movement SHALL discard all blocks; first spawn after release SHALL occur on the SPAWN_TICKS-th move_tick.

Configuration
REQ-030 Macro RANDOM_BLOCK_COLOR_EN defined: each slot SHALL latch colour {lfsr[15:12], lfsr[11:8], lfsr[3:0]} at spawn, forced to 4'hF red if all three are zero; hit outputs that colour.
REQ-031 Macro RANDOM_BLOCK_COLOR_EN undefined: every hit SHALL output R=4'hF, G=4'h0, B=4'h0, no colour storage.

Verification
REQ-032 Reset then 16 move_ticks with LFSR forced to candidate 200, res 640x480 -> slot0 ACTIVE, x=639, y=200, active=4'b0001.
REQ-033 Slot0 at x=639, 3 move_ticks -> x=630; xpos=625, ypos=195, disp_active=1 -> R=4'hF one clock later; disp_active=0 -> R=G=B=0.
REQ-034 Slot at x=13 (BLOCK_SIZE+STEP), move_tick -> x=10; next move_tick -> IDLE, active bit cleared.
REQ-035 All 4 slots ACTIVE, valid spawn -> no slot change, drop_count 0->1; 300 such spawns -> drop_count=255.
REQ-036 Candidate 5 (<BLOCK_SIZE) at spawn -> no spawn; next move_tick with candidate 300 -> spawn y=300, no drop counted.
REQ-037 reset_n pulsed low asynchronously between clock edges with 3 slots ACTIVE -> active=0 and R=G=B=0 before next clock edge.
